// File: rtl/if_prefetch_unit.sv
// RV32I fetch front end: request/response imem port, in-order prefetch queue.
// Optional perf counters when FETCH_PERF_EN is defined.
module if_prefetch_unit #(
  parameter int              XLEN      = 32,
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [XLEN-1:0] inst_data,
  output logic [XLEN-1:0] inst_pc,
  output logic            busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_stall
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int SW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

  typedef enum logic {
    S_RUN,
    S_DRAIN
  } state_e;

  state_e          state_q, state_d;
  logic            go_q;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]   outst_q, outst_d;
  logic [CW-1:0]   stale_q, stale_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [SW-1:0]   sf_wr_q, sf_wr_d;
  logic [SW-1:0]   sf_rd_q, sf_rd_d;

  logic [XLEN-1:0] q_data_q [DEPTH];
  logic [XLEN-1:0] q_pc_q   [DEPTH];
  logic [XLEN-1:0] sf_pc_q  [MAX_OUTST];

  logic            gnt_fire;
  logic            rsp_ok;
  logic            push;
  logic            pop;
  logic            room;
  logic            drain_exit;
  logic [CW:0]     level;

  function automatic logic [SW-1:0] sf_inc(
    input logic [SW-1:0] p
  );
    return (p == SW'(MAX_OUTST - 1)) ? '0 : p + SW'(1);
  endfunction

  assign gnt_fire = imem_req & imem_gnt;
  assign rsp_ok   = imem_rvalid & (outst_q != '0);
  assign level    = {1'b0, cnt_q} + {1'b0, outst_q};

  // Reserve queue slots for every word in flight so a push never overflows.
  assign room = go_q
             && (level < (CW+1)'(DEPTH))
             && (outst_q < CW'(MAX_OUTST));

  assign drain_exit = (state_q == S_DRAIN)
                   && rsp_ok
                   && (stale_q == CW'(1));

  assign imem_req = !redirect_valid
                 && (((state_q == S_RUN) && room) || drain_exit);

  assign imem_addr  = fetch_pc_q;
  assign busy       = (state_q == S_DRAIN);
  assign inst_valid = (cnt_q != '0);
  assign inst_data  = inst_valid ? q_data_q[rd_q] : '0;
  assign inst_pc    = inst_valid ? q_pc_q[rd_q] : '0;

  assign push = (state_q == S_RUN) && rsp_ok && !redirect_valid;
  assign pop  = inst_valid && inst_ready && !redirect_valid;

  always_comb begin
    state_d    = state_q;
    stale_d    = stale_q;
    outst_d    = outst_q + CW'(gnt_fire) - CW'(rsp_ok);
    fetch_pc_d = gnt_fire ? fetch_pc_q + XLEN'(4) : fetch_pc_q;
    unique case (1'b1)
      redirect_valid: begin
        fetch_pc_d = redirect_pc & ~XLEN'(3);
        stale_d    = outst_d;
        state_d    = (outst_d != '0) ? S_DRAIN : S_RUN;
      end
      (state_q == S_DRAIN) && rsp_ok && !redirect_valid: begin
        stale_d = stale_q - CW'(1);
        if (stale_q == CW'(1)) begin
          state_d = S_RUN;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q + CW'(push) - CW'(pop);
    wr_d    = wr_q + AW'(push);
    rd_d    = rd_q + AW'(pop);
    sf_wr_d = gnt_fire ? sf_inc(sf_wr_q) : sf_wr_q;
    sf_rd_d = rsp_ok ? sf_inc(sf_rd_q) : sf_rd_q;
    if (redirect_valid) begin
      cnt_d = '0;
      wr_d  = '0;
      rd_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_RUN;
      go_q       <= 1'b0;
      fetch_pc_q <= RESET_PC;
      outst_q    <= '0;
      stale_q    <= '0;
      cnt_q      <= '0;
      wr_q       <= '0;
      rd_q       <= '0;
      sf_wr_q    <= '0;
      sf_rd_q    <= '0;
    end else begin
      state_q    <= state_d;
      go_q       <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      outst_q    <= outst_d;
      stale_q    <= stale_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      sf_wr_q    <= sf_wr_d;
      sf_rd_q    <= sf_rd_d;
    end
  end

  // PC of each granted request waits here until its response returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MAX_OUTST; i++) begin
        sf_pc_q[i] <= '0;
      end
    end else if (gnt_fire) begin
      sf_pc_q[sf_wr_q] <= fetch_pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_data_q[i] <= '0;
        q_pc_q[i]   <= '0;
      end
    end else if (push) begin
      q_data_q[wr_q] <= imem_rdata;
      q_pc_q[wr_q]   <= sf_pc_q[sf_rd_q];
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q;
  logic [31:0] perf_stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_q <= '0;
      perf_stall_q   <= '0;
    end else begin
      if (inst_valid && inst_ready && (perf_fetched_q != '1)) begin
        perf_fetched_q <= perf_fetched_q + 32'd1;
      end
      if (inst_ready && !inst_valid && (perf_stall_q != '1)) begin
        perf_stall_q <= perf_stall_q + 32'd1;
      end
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stall   = perf_stall_q;
`endif

`ifndef SYNTHESIS
  a_no_overflow: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(push && !pop && (cnt_q == CW'(DEPTH)))
  );

  a_rvalid_outst: assert property (
    @(posedge clk) disable iff (!rst_n)
    !(imem_rvalid && (outst_q == '0))
  );
`endif

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: memory model, issue monitor,
// directed fetch/redirect scenarios.
module tb_if_prefetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stall;
`endif

  if_prefetch_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched   (perf_fetched),
    .perf_stall     (perf_stall)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  logic        resp_en = 1'b0;
  logic        forbid  = 1'b0;
  logic [31:0] pend[$];
  logic [31:0] grant_log[$];
  logic [31:0] exp_pc[$];
  int          pop_log[$];

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, req);
    end
  endtask

  // Memory model: record grants, answer in order one cycle later.
  always @(negedge clk) begin
    if (rst_n && imem_req && imem_gnt) begin
      pend.push_back(imem_addr);
      grant_log.push_back(imem_addr);
      if (forbid) begin
        chk("no_old_target", 32'(imem_addr[31:8] != 24'h1), 32'd1);
      end
    end
  end

  always @(posedge clk) begin : mem_drv
    logic [31:0] a;
    #2;
    if (!rst_n) begin
      pend.delete();
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else if (resp_en && pend.size() != 0) begin
      a = pend.pop_front();
      imem_rvalid = 1'b1;
      imem_rdata  = word(a);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end
  end

  // Issue monitor: every handshake must match the next expected PC.
  always @(negedge clk) begin : mon
    logic [31:0] e;
    cyc++;
    if (rst_n && inst_valid && inst_ready) begin
      pop_log.push_back(cyc);
      if (exp_pc.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_issue: got pc %h expected none",
                 inst_pc);
      end else begin
        e = exp_pc.pop_front();
        chk("issue_pc", inst_pc, e);
        chk("issue_data", inst_data, word(e));
      end
    end
  end

  task automatic push_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      exp_pc.push_back(base + 32'(4 * i));
    end
  endtask

  task automatic wait_exp(input string nm, input int budget);
    int n = 0;
    while (exp_pc.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(nm, 32'(exp_pc.size()), 32'd0);
  endtask

  task automatic do_reset(input logic g, input logic r, input logic rd);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_gnt       = 1'b0;
    resp_en        = 1'b0;
    inst_ready     = 1'b0;
    forbid         = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_data", inst_data, 32'd0);
    chk("rst_pc", inst_pc, 32'd0);
    exp_pc.delete();
    grant_log.delete();
    pop_log.delete();
    @(posedge clk);
    #1;
    imem_gnt   = g;
    resp_en    = r;
    inst_ready = rd;
    rst_n      = 1'b1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    @(posedge clk);
    #1;
    redirect_valid = 1'b1;
    redirect_pc    = pc;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    imem_gnt       = 1'b0;
    imem_rvalid    = 1'b0;
    imem_rdata     = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    inst_ready     = 1'b0;

    // Streaming fetch from reset.
    do_reset(1'b1, 1'b1, 1'b1);
    push_run(32'h0, 16);
    wait_exp("t1_drain", 100);
    inst_ready = 1'b0;
    imem_gnt   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", grant_log[i], 32'(4 * i));
    end
    if (pop_log.size() > 0) begin
      chk("t1_sustained", 32'(pop_log[$] - pop_log[0]), 32'd15);
    end

    // Back-pressure fills the queue, then release.
    do_reset(1'b1, 1'b1, 1'b0);
    repeat (15) @(posedge clk);
    @(negedge clk);
    chk("t2_grants", 32'(grant_log.size()), 32'd4);
    chk("t2_req_off", 32'(imem_req), 32'd0);
    chk("t2_valid", 32'(inst_valid), 32'd1);
    chk("t2_head_pc", inst_pc, 32'h0);
    push_run(32'h0, 8);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    wait_exp("t2_drain", 60);
    inst_ready = 1'b0;
    imem_gnt   = 1'b0;
    if (grant_log.size() > 4) begin
      chk("t2_resume", grant_log[4], 32'h10);
    end

    // Redirect with two requests in flight.
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t3_outst", 32'(grant_log.size()), 32'd2);
    grant_log.delete();
    push_run(32'h100, 8);
    redirect(32'h100);
    @(negedge clk);
    chk("t3_no_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    @(negedge clk);
    chk("t3_busy", 32'(busy), 32'd1);
    wait_exp("t3_drain", 60);
    inst_ready = 1'b0;
    imem_gnt   = 1'b0;
    if (grant_log.size() > 0) begin
      chk("t3_first_addr", grant_log[0], 32'h100);
    end
    chk("t3_busy_end", 32'(busy), 32'd0);

    // Redirect with nothing outstanding, misaligned target.
    do_reset(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    redirect(32'h203);
    @(negedge clk);
    chk("t4_no_req", 32'(imem_req), 32'd0);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    @(negedge clk);
    chk("t4_busy", 32'(busy), 32'd0);
    chk("t4_req", 32'(imem_req), 32'd1);
    chk("t4_addr", imem_addr, 32'h200);
    push_run(32'h200, 4);
    @(posedge clk);
    #1;
    imem_gnt   = 1'b1;
    resp_en    = 1'b1;
    inst_ready = 1'b1;
    wait_exp("t4_drain", 60);
    inst_ready = 1'b0;
    imem_gnt   = 1'b0;

    // Second redirect while draining the first.
    do_reset(1'b1, 1'b0, 1'b1);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("t5_outst", 32'(grant_log.size()), 32'd2);
    grant_log.delete();
    push_run(32'h400, 4);
    redirect(32'h100);
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    @(posedge clk);
    #1;
    resp_en        = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h400;
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    resp_en        = 1'b1;
    forbid         = 1'b1;
    @(negedge clk);
    chk("t5_busy", 32'(busy), 32'd1);
    wait_exp("t5_drain", 60);
    forbid     = 1'b0;
    inst_ready = 1'b0;
    imem_gnt   = 1'b0;
    if (grant_log.size() > 0) begin
      chk("t5_first_addr", grant_log[0], 32'h400);
    end

`ifdef FETCH_PERF_EN
    do_reset(1'b0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    inst_ready = 1'b0;
    imem_gnt   = 1'b1;
    push_run(32'h0, 10);
    repeat (12) @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    inst_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    inst_ready = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    inst_ready = 1'b0;
    wait_exp("perf_drain", 20);
    @(negedge clk);
    chk("perf_fetched", perf_fetched, 32'd10);
    chk("perf_stall", perf_stall, 32'd3);
    rst_n = 1'b0;
    @(negedge clk);
    chk("perf_fetched_rst", perf_fetched, 32'd0);
    chk("perf_stall_rst", perf_stall, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
- Parametrised instruction-fetch front end for the next-generation RV32I core.
- Replaces direct PC-to-instruction-memory addressing with a request/response memory interface, a DEPTH-entry in-order prefetch queue, and a valid/ready issue handshake toward decode.
- Handles branch/jump redirects from the execute stage: flushes queued words and discards responses that are still in flight.

Parameters:
- XLEN, 32, address/instruction width in bits.
- DEPTH, 4, prefetch queue entries; power of two, 2..16.
- MAX_OUTST, 2, maximum outstanding memory requests; 1..DEPTH.
- RESET_PC, 32'h00000000, first fetch address after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch address, word aligned.
- imem_gnt  in  1  request accepted this cycle (handshake imem_req & imem_gnt).
- imem_rvalid  in  1  response valid; responses return in request order, at least 1 cycle after grant.
- imem_rdata  in  XLEN  response instruction word.
- redirect_valid  in  1  taken branch/jump; single-cycle pulse.
- redirect_pc  in  XLEN  new fetch target.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  XLEN  head instruction.
- inst_pc  out  XLEN  PC of head instruction.
- busy  out  1  high in DRAIN state.

Behaviour:
- Reset (async assert, sync deassert handled upstream): fetch_pc=RESET_PC; queue empty; outstanding=0; stale=0; state=RUN. Outputs: imem_req=0, inst_valid=0, busy=0; inst_data and inst_pc are 0.
- States: RUN and DRAIN.
- RUN: imem_req=1 when (count+outstanding) < DEPTH and outstanding < MAX_OUTST. imem_addr=fetch_pc. On grant: fetch_pc += 4 (wraps modulo 2^XLEN) and outstanding += 1.
- Each request records its PC in a side FIFO of MAX_OUTST entries. On rvalid in RUN, {rdata, pc} is pushed to the queue.
- The queue reservation rule guarantees no push overflow; an assertion flags an overflow as an error.
- Issue: inst_valid = count != 0. A pop occurs on inst_valid & inst_ready. Head-to-output is combinational from the queue; queue-to-issue latency is 0 cycles. Minimum latency from grant to inst_valid is 1 cycle after rvalid.
- Simultaneous push and pop on the same cycle are both performed; count is unchanged. Push into an empty queue shows inst_valid the next cycle (no bypass).
- redirect_valid (any state, highest priority):
  - Queue flushed (count=0, pointers reset). inst_valid drops the next cycle.
  - fetch_pc=redirect_pc with bits [1:0] forced to 0.
  - stale = outstanding after this cycle's grant/response accounting. No request is issued in the redirect cycle.
  - If stale != 0, go to DRAIN; otherwise stay in RUN.
- DRAIN: busy=1; imem_req=0. Each rvalid is discarded and decrements stale and outstanding. When stale reaches 0, return to RUN and issue requests the same cycle.
- A redirect during DRAIN reloads fetch_pc. stale equals the remaining outstanding count.
- rvalid with outstanding=0 is a protocol error; it is ignored and flagged by an assertion.
- Reset asserted mid-transaction: all state clears immediately. The memory side is reset by the same rst_n.

Optional Feature:
- FETCH_PERF_EN defined: adds outputs perf_fetched (32 bits) and perf_stall (32 bits).
  - perf_fetched counts pops.
  - perf_stall counts cycles with inst_ready=1 and inst_valid=0.
  - Both counters saturate at all-ones and clear on reset.
- FETCH_PERF_EN undefined: the ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset release, memory grants every cycle with 1-cycle rvalid, inst_ready=1 -> imem_addr 0x0,0x4,0x8,...; inst_pc matches each address; inst_data equals the programmed words; sustained one pop per cycle after fill.
- inst_ready=0 held, DEPTH=4 -> exactly 4 grants; imem_req stays 0 afterward; inst_valid=1 with inst_pc=0x0. Release ready -> 4 pops then fetch resumes at 0x10.
- Redirect to 0x100 while 2 requests are outstanding -> busy=1, next 2 rvalid words are dropped (never on inst_data), then imem_addr=0x100 and first inst_pc=0x100.
- Redirect to 0x203 with nothing outstanding -> stays in RUN, busy=0, next imem_addr=0x200.
- Redirect during DRAIN to 0x400 -> remaining stale responses dropped, next fetch at 0x400; the prior target's address is never requested.
- FETCH_PERF_EN: 10 pops plus 3 ready-without-valid cycles -> perf_fetched=10, perf_stall=3; assert rst_n -> both 0.
